tron_scoreboard: RTL and testbench
==================================

Name: tron_scoreboard

Overview:
- Parametrised multi-player score tracker for the Tron game.
- Counts round wins per player in packed BCD, filters round-win strobes through edge detection and a post-round hold-off, and detects match end at a target score.
- Sits between the game-logic round-result outputs and the HEX display decoders.
- Display decode stays outside this block.

Parameters:
NUM_PLAYERS, 2, number of players/score channels (2..8)
DIGITS, 2, BCD digits per player score (1..4)
WIN_SCORE, 10, score that ends the match (1 .. 10^DIGITS-1)
HOLD_CYCLES, 4, cycles after a round result during which further wins are ignored (>=1)
PW, $clog2(NUM_PLAYERS) (min 1), width of winner index (derived, localparam)

Ports:
clk  input  1  system clock, all state on rising edge
clear_b  input  1  asynchronous active-low reset
enable  input  1  count enable; win edges while low are discarded
new_match  input  1  synchronous clear of scores and match state
win_in  input  NUM_PLAYERS  round-win level per player, bit i = player i won
score_bcd  output  NUM_PLAYERS*DIGITS*4  packed BCD; player i at [i*DIGITS*4 +: DIGITS*4], least-significant digit lowest
round_done  output  1  one-cycle pulse: a single player's win was counted
draw  output  1  one-cycle pulse: two or more players won on the same edge
match_over  output  1  high while state is OVER
winner  output  PW  index of match winner, valid when match_over
busy  output  1  high in HOLD (round results ignored)

Behaviour:
- Reset (clear_b low, async): all scores 0, win_q 0, state PLAY, hold counter 0; round_done, draw, match_over, busy low; winner 0.
- Edge detect: win_q <= win_in every cycle in every state, including while enable is low. rise = win_in & ~win_q. A level held across a disabled period or HOLD never re-triggers.
- States PLAY, HOLD, OVER.
- PLAY, enable=1, rise has exactly one bit i set:
  - Player i score increments by 1 in BCD: digit 9 -> 0 with carry into the next digit.
  - New score is visible on score_bcd after the same edge that sampled the rise.
  - round_done is high for the following cycle.
  - If the new score == WIN_SCORE: go to OVER, winner <= i, match_over high next cycle.
  - Otherwise: go to HOLD, hold counter <= HOLD_CYCLES-1.
- PLAY, enable=1, rise has >=2 bits set: no score change; draw pulses one cycle; go to HOLD.
- PLAY, enable=0 or rise=0: no action.
- HOLD: busy=1. All rises are ignored. Counter decrements each cycle; at 0 go to PLAY. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- OVER: scores frozen, wins ignored, winner and match_over held until new_match or reset.
- new_match=1 (any state): next edge clears scores, winner, pulses and hold counter, and sets state to PLAY. It has priority over a rise on the same edge; that rise is discarded. win_q still samples.
- Saturation: a score never exceeds WIN_SCORE, because the match ends on reaching it. No wrap past 10^DIGITS-1 is possible.
- round_done and draw are mutually exclusive and never asserted in OVER.
- Reset mid-HOLD or mid-OVER returns to the reset values immediately (async).

Test Plan:
- Reset then single strobe: NUM_PLAYERS=2, pulse win_in=2'b01 for one cycle -> score_bcd player0=0x01, player1=0x00; round_done one cycle; busy high for 4 cycles.
- BCD carry: drive 10 separate player-1 wins, each spaced > HOLD_CYCLES apart, with WIN_SCORE=25 -> player-1 field reads 0x10 after the 10th. Digits never show A-F.
- Match end: WIN_SCORE=3, three player-0 wins -> after the 3rd, match_over=1, winner=0, busy=0. A 4th win strobe leaves the score at 0x03. new_match -> all scores 0x00, match_over=0.
- Draw and hold-off: win_in=2'b11 on one edge -> draw pulse, scores unchanged. A player-0 win arriving 2 cycles later (inside HOLD) is ignored. A player-0 win after HOLD counts (score 0x01).
- Level and enable handling: hold win_in[1]=1 for 20 cycles -> counted once. Rise with enable=0 -> not counted, and not counted later when enable rises while the level is still held.
- Async reset mid-HOLD and new_match colliding with a win on the same edge -> scores 0, state PLAY, no round_done.

Source files
------------

// File: rtl/tron_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tron_scoreboard
//  Brief    : Multi-player Tron round-win counter. It keeps a packed BCD score
//             for each player, edge-detects the win strobes, ignores results
//             during a post-round hold-off, and flags the end of the match
//             when a player reaches the target score.
//  Revision : 1.0  initial release
// ============================================================================
module tron_scoreboard #(
    parameter  int NUM_PLAYERS = 2,
    parameter  int DIGITS      = 2,
    parameter  int WIN_SCORE   = 10,
    parameter  int HOLD_CYCLES = 4,
    localparam int PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                            clk,
    input  logic                            clear_b,
    input  logic                            enable,
    input  logic                            new_match,
    input  logic [NUM_PLAYERS-1:0]          win_in,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
    output logic                            round_done,
    output logic                            draw,
    output logic                            match_over,
    output logic [PW-1:0]                   winner,
    output logic                            busy
);

    localparam int c_DW = DIGITS * 4;
    localparam int c_HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] c_ST_PLAY = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
    localparam logic [1:0] c_ST_OVER = 2'd2;

    // Binary-to-BCD conversion of an elaboration-time constant.
    function automatic logic [c_DW-1:0] f_to_bcd(input int value);
        logic [c_DW-1:0] result;
        int              rem;
        result = '0;
        rem    = value;
        for (int d = 0; d < DIGITS; d++) begin
            result[d*4 +: 4] = 4'(rem % 10);
            rem              = rem / 10;
        end
        return result;
    endfunction

    // Add one to a packed BCD number, rippling the carry through 9 -> 0 digits.
    function automatic logic [c_DW-1:0] f_bcd_inc(input logic [c_DW-1:0] value);
        logic [c_DW-1:0] result;
        logic            carry;
        result = value;
        carry  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (result[d*4 +: 4] == 4'd9) begin
                    result[d*4 +: 4] = 4'd0;
                end else begin
                    result[d*4 +: 4] = result[d*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

    localparam logic [c_DW-1:0] c_WIN_BCD   = f_to_bcd(WIN_SCORE);
    localparam logic [c_HW-1:0] c_HOLD_INIT = c_HW'(HOLD_CYCLES - 1);
    localparam logic [c_HW-1:0] c_HOLD_ONE  = c_HW'(1);

    logic [NUM_PLAYERS-1:0]        r_win_q;
    logic [1:0]                    r_state;
    logic [c_HW-1:0]               r_hold;
    logic [NUM_PLAYERS*c_DW-1:0]   r_score;
    logic                          r_round_done;
    logic                          r_draw;
    logic [PW-1:0]                 r_winner;

    logic [NUM_PLAYERS-1:0]        w_rise;
    logic                          w_single;
    logic                          w_multi;
    logic [PW-1:0]                 w_idx;
    logic [c_DW-1:0]               w_cur;
    logic [c_DW-1:0]               w_inc;

    assign w_rise   = win_in & ~r_win_q;
    assign w_single = $onehot(w_rise);
    assign w_multi  = (w_rise != '0) && !w_single;

    // Index of the rising player; only meaningful when exactly one bit rose.
    always_comb begin
        w_idx = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_rise[p]) begin
                w_idx = PW'(p);
            end
        end
    end

    assign w_cur = r_score[w_idx*c_DW +: c_DW];
    assign w_inc = f_bcd_inc(w_cur);

    // Win-level history: sampled every cycle regardless of state or enable so
    // a level held through a disabled or hold-off window never re-triggers.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            r_win_q <= '0;
        end else begin
            r_win_q <= win_in;
        end
    end

    // Round/match state machine with score update and result pulses.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            r_state      <= c_ST_PLAY;
            r_hold       <= '0;
            r_score      <= '0;
            r_round_done <= 1'b0;
            r_draw       <= 1'b0;
            r_winner     <= '0;
        end else if (new_match) begin
            // A new match overrides any win arriving on the same edge.
            r_state      <= c_ST_PLAY;
            r_hold       <= '0;
            r_score      <= '0;
            r_round_done <= 1'b0;
            r_draw       <= 1'b0;
            r_winner     <= '0;
        end else begin
            r_round_done <= 1'b0;
            r_draw       <= 1'b0;
            case (r_state)
                c_ST_PLAY: begin
                    if (enable && w_single) begin
                        r_score[w_idx*c_DW +: c_DW] <= w_inc;
                        r_round_done                <= 1'b1;
                        if (w_inc == c_WIN_BCD) begin
                            r_state  <= c_ST_OVER;
                            r_winner <= w_idx;
                        end else begin
                            r_state <= c_ST_HOLD;
                            r_hold  <= c_HOLD_INIT;
                        end
                    end else if (enable && w_multi) begin
                        r_draw  <= 1'b1;
                        r_state <= c_ST_HOLD;
                        r_hold  <= c_HOLD_INIT;
                    end
                end
                c_ST_HOLD: begin
                    if (r_hold == '0) begin
                        r_state <= c_ST_PLAY;
                    end else begin
                        r_hold <= r_hold - c_HOLD_ONE;
                    end
                end
                c_ST_OVER: begin
                    r_state <= c_ST_OVER;
                end
                default: begin
                    r_state <= c_ST_PLAY;
                end
            endcase
        end
    end

    assign score_bcd  = r_score;
    assign round_done = r_round_done;
    assign draw       = r_draw;
    assign winner     = r_winner;
    assign match_over = (r_state == c_ST_OVER);
    assign busy       = (r_state == c_ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_tron_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tron_scoreboard
//  Brief    : Self-checking bench for tron_scoreboard (2 players, 2 digits,
//             target 12, hold-off 4). A behavioural model queues the expected
//             outputs for every clock edge; they are popped and compared just
//             after that edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tron_scoreboard;

    localparam int NP   = 2;
    localparam int DG   = 2;
    localparam int WIN  = 12;
    localparam int HOLD = 4;
    localparam int TPW  = 1;

    logic                 clk;
    logic                 clear_b;
    logic                 enable;
    logic                 new_match;
    logic [NP-1:0]        win_in;
    logic [NP*DG*4-1:0]   score_bcd;
    logic                 round_done;
    logic                 draw;
    logic                 match_over;
    logic [TPW-1:0]       winner;
    logic                 busy;

    tron_scoreboard #(
        .NUM_PLAYERS (NP),
        .DIGITS      (DG),
        .WIN_SCORE   (WIN),
        .HOLD_CYCLES (HOLD)
    ) u_dut (
        .clk        (clk),
        .clear_b    (clear_b),
        .enable     (enable),
        .new_match  (new_match),
        .win_in     (win_in),
        .score_bcd  (score_bcd),
        .round_done (round_done),
        .draw       (draw),
        .match_over (match_over),
        .winner     (winner),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] score;
        logic        rd;
        logic        dr;
        logic        mo;
        logic        wn;
        logic        bz;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_bad   = 0;

    // Model state: 0 = play, 1 = hold, 2 = over.
    int       m_st;
    int       m_hold;
    int       m_s0;
    int       m_s1;
    int       m_win;
    logic     m_rd;
    logic     m_dr;
    logic [1:0] m_winq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_hold = 0; m_s0 = 0; m_s1 = 0; m_win = 0;
        m_rd = 1'b0; m_dr = 1'b0; m_winq = 2'b00;
    endtask

    task automatic model_step();
        logic [1:0] rise;
        exp_t       e;
        rise   = win_in & ~m_winq;
        m_winq = win_in;
        if (new_match) begin
            m_st = 0; m_hold = 0; m_s0 = 0; m_s1 = 0; m_win = 0;
            m_rd = 1'b0; m_dr = 1'b0;
        end else begin
            m_rd = 1'b0;
            m_dr = 1'b0;
            if (m_st == 0) begin
                if (enable && rise != 2'b00) begin
                    if (rise == 2'b11) begin
                        m_dr = 1'b1; m_st = 1; m_hold = HOLD - 1;
                    end else begin
                        int sc;
                        m_rd = 1'b1;
                        if (rise[1]) begin m_s1++; sc = m_s1; end
                        else         begin m_s0++; sc = m_s0; end
                        if (sc == WIN) begin
                            m_st = 2; m_win = rise[1] ? 1 : 0;
                        end else begin
                            m_st = 1; m_hold = HOLD - 1;
                        end
                    end
                end
            end else if (m_st == 1) begin
                if (m_hold == 0) m_st = 0;
                else             m_hold--;
            end
        end
        e.score = {to_bcd(m_s1), to_bcd(m_s0)};
        e.rd    = m_rd;
        e.dr    = m_dr;
        e.mo    = (m_st == 2);
        e.wn    = (m_win == 1);
        e.bz    = (m_st == 1);
        exp_q.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("score_bcd",  32'(score_bcd),  32'(e.score));
            check("round_done", 32'(round_done), 32'(e.rd));
            check("draw",       32'(draw),       32'(e.dr));
            check("match_over", 32'(match_over), 32'(e.mo));
            check("winner",     32'(winner),     32'(e.wn));
            check("busy",       32'(busy),       32'(e.bz));
        end
    endtask

    task automatic cyc(input logic [1:0] w, input logic en, input logic nm);
        @(negedge clk);
        win_in    = w;
        enable    = en;
        new_match = nm;
        model_step();
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(2'b00, 1'b1, 1'b0);
    endtask

    // One-cycle win pulse followed by enough idle cycles to clear the hold-off.
    task automatic strobe(input logic [1:0] w);
        cyc(w, 1'b1, 1'b0);
        idle(HOLD + 2);
    endtask

    initial begin
        clear_b   = 1'b1;
        enable    = 1'b1;
        new_match = 1'b0;
        win_in    = 2'b00;
        model_reset();

        // Asynchronous reset before any clock edge.
        #2 clear_b = 1'b0;
        #1;
        check("rst_score",  32'(score_bcd),  32'h0);
        check("rst_rd",     32'(round_done), 32'h0);
        check("rst_mo",     32'(match_over), 32'h0);
        check("rst_busy",   32'(busy),       32'h0);
        check("rst_winner", 32'(winner),     32'h0);
        #21 clear_b = 1'b1;
        idle(2);

        // Single strobe for player 0, busy for exactly HOLD cycles.
        strobe(2'b01);
        check("p0_after_one", 32'(score_bcd), 32'h0001);

        // Draw, a win inside the hold-off, then a win after it.
        cyc(2'b11, 1'b1, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b01, 1'b1, 1'b0);
        idle(HOLD + 2);
        strobe(2'b01);
        check("p0_after_draw", 32'(score_bcd), 32'h0002);

        // Level held for 20 cycles counts once.
        for (int k = 0; k < 20; k++) cyc(2'b10, 1'b1, 1'b0);
        idle(HOLD + 2);
        check("level_once", 32'(score_bcd), 32'h0102);

        // Rise while disabled is dropped, also once enable returns.
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(2'b10, 1'b1, 1'b0);
        idle(2);
        check("enable_drop", 32'(score_bcd), 32'h0102);

        // BCD carry: player 1 goes from 1 to 10.
        for (int k = 0; k < 9; k++) strobe(2'b10);
        check("bcd_carry", 32'(score_bcd), 32'h1002);

        // Player 1 reaches the target and wins the match.
        strobe(2'b10);
        cyc(2'b10, 1'b1, 1'b0);
        check("over_mo",     32'(match_over), 32'h1);
        check("over_winner", 32'(winner),     32'h1);
        check("over_busy",   32'(busy),       32'h0);
        idle(2);
        strobe(2'b10);
        strobe(2'b01);
        check("over_frozen", 32'(score_bcd), 32'h1202);

        // New match clears everything.
        cyc(2'b00, 1'b1, 1'b1);
        check("nm_score", 32'(score_bcd),  32'h0);
        check("nm_mo",    32'(match_over), 32'h0);
        idle(2);

        // New match colliding with a win on the same edge.
        cyc(2'b01, 1'b1, 1'b1);
        check("collide_rd", 32'(round_done), 32'h0);
        cyc(2'b01, 1'b1, 1'b0);
        idle(3);
        check("collide_score", 32'(score_bcd), 32'h0);

        // Asynchronous reset in the middle of HOLD.
        strobe(2'b01);
        cyc(2'b10, 1'b1, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        #2 clear_b = 1'b0;
        #1;
        check("arst_score", 32'(score_bcd),  32'h0);
        check("arst_busy",  32'(busy),       32'h0);
        check("arst_rd",    32'(round_done), 32'h0);
        model_reset();
        clear_b = 1'b1;
        idle(2);
        strobe(2'b01);
        check("post_arst", 32'(score_bcd), 32'h0001);

        check("queue_left", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
